// File: rtl/pl_fetch_stage_pkg.sv
// ============================================================================
// Module      : pl_fetch_stage_pkg
// Description : Shared fetch-stage definitions: datapath width, default reset
//               PC, FSM state encodings and PC increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pl_fetch_stage_pkg;

    localparam int unsigned       c_XLEN     = 32;
    localparam logic [c_XLEN-1:0] c_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_REQ  = c_ST_REQ,
        ST_WAIT = c_ST_WAIT,
        ST_HOLD = c_ST_HOLD
    } fetch_state_e;

    function automatic logic [c_XLEN-1:0] pc_inc(input logic [c_XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pl_fetch_stage_pc_reg.sv
// ============================================================================
// Module      : pl_pc_reg
// Description : Program counter register with load enable and next-PC select
//               between sequential (PC+4) and redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pl_pc_reg
    import pl_fetch_stage_pkg::*;
#(
    parameter logic [c_XLEN-1:0] RESET_PC = c_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              sel_target,
    input  logic [c_XLEN-1:0] target,
    output logic [c_XLEN-1:0] pc,
    output logic [c_XLEN-1:0] pc_plus4,
    output logic [c_XLEN-1:0] pc_d
);

    logic [c_XLEN-1:0] r_pc;
    logic [c_XLEN-1:0] w_pc_plus4;

    assign w_pc_plus4 = pc_inc(r_pc);

    // pc_d is the value the register holds after the coming edge
    always_comb begin
        pc_d = r_pc;
        if (load_en) begin
            pc_d = sel_target ? target : w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= pc_d;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;

endmodule

`default_nettype wire

// File: rtl/pl_fetch_stage.sv
// ============================================================================
// Module      : pl_fetch_stage
// Description : Pipeline fetch stage with single-outstanding instruction
//               memory requests, stall hold buffer and redirect squashing.
//               Optional performance counters when FETCH_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pl_fetch_stage
    import pl_fetch_stage_pkg::*;
#(
    parameter logic [c_XLEN-1:0] RESET_PC = c_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallF,
    input  logic              PCSrcE,
    input  logic [c_XLEN-1:0] PCTargetE,
    output logic              imem_req_valid,
    output logic [c_XLEN-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [c_XLEN-1:0] imem_rsp_data,
    output logic [c_XLEN-1:0] InstrF,
    output logic [c_XLEN-1:0] PCF,
    output logic [c_XLEN-1:0] PCPlus4F,
    output logic              InstrValidF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_squash_cnt
`endif
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [c_XLEN-1:0] r_addr;
    logic [c_XLEN-1:0] r_hold;
    logic              r_squash;
    logic              w_squash_nxt;
    logic              w_hold_load;
    logic              w_addr_load;
    logic              w_discard;
    logic              w_instr_valid;
    logic              w_consume;
    logic [c_XLEN-1:0] w_pc_d;

    pl_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (w_consume | PCSrcE),
        .sel_target (PCSrcE),
        .target     (PCTargetE),
        .pc         (PCF),
        .pc_plus4   (PCPlus4F),
        .pc_d       (w_pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect never yields a valid instruction, so every valid path below
    // is guarded by !PCSrcE.
    always_comb begin
        w_state_nxt    = r_state;
        w_squash_nxt   = r_squash;
        w_hold_load    = 1'b0;
        w_addr_load    = 1'b0;
        w_discard      = 1'b0;
        w_instr_valid  = 1'b0;
        imem_req_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_addr_load = 1'b1;
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                imem_req_valid = 1'b1;
                if (PCSrcE) begin
                    w_squash_nxt = 1'b1;
                end
                if (imem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_squash || PCSrcE) begin
                        w_squash_nxt = 1'b0;
                        w_discard    = 1'b1;
                        w_addr_load  = 1'b1;
                        w_state_nxt  = ST_REQ;
                    end else begin
                        w_instr_valid = 1'b1;
                        if (StallF) begin
                            w_hold_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_addr_load = 1'b1;
                            w_state_nxt = ST_REQ;
                        end
                    end
                end else if (PCSrcE) begin
                    w_squash_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (PCSrcE) begin
                    w_discard   = 1'b1;
                    w_addr_load = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_instr_valid = 1'b1;
                    if (!StallF) begin
                        w_addr_load = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_consume   = w_instr_valid & ~StallF;
    assign InstrValidF = w_instr_valid;
    assign InstrF      = !w_instr_valid      ? '0     :
                         (r_state == ST_HOLD) ? r_hold : imem_rsp_data;
    assign imem_req_addr = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= RESET_PC;
            r_hold   <= '0;
            r_squash <= 1'b0;
        end else begin
            r_squash <= w_squash_nxt;
            if (w_addr_load) begin
                r_addr <= w_pc_d;
            end
            if (w_hold_load) begin
                r_hold <= imem_rsp_data;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_squash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch  <= '0;
            r_perf_squash <= '0;
        end else begin
            if (w_consume) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_discard) begin
                r_perf_squash <= r_perf_squash + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch;
    assign perf_squash_cnt = r_perf_squash;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pl_fetch_stage.sv
// ============================================================================
// Module      : tb_pl_fetch_stage
// Description : Self-checking bench for pl_fetch_stage: directed scenarios and
//               randomized traffic against an architectural PC/instruction model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pl_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    always #5 clk = ~clk;

    pl_fetch_stage #(
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .InstrValidF    (InstrValidF)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_squash_cnt (perf_squash_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a pure function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0001;
    endfunction

    // Stimulus knobs
    int          p_stall, p_redir, p_ready, lat_max, stall_hold;
    bit          force_redir;
    logic [31:0] forced_target;

    // Memory model and reference state
    bit          mem_pending;
    logic [31:0] mem_addr;
    int          mem_lat;
    logic [31:0] model_pc;
    bit          prev_hold, prev_req_blocked;
    logic [31:0] prev_instr, prev_addr;
    int          cyc, n_consumed, model_squash;
    logic [31:0] acc_q[$];
    logic [31:0] con_q[$];
    int          con_cyc_q[$];

    task automatic drive_inputs();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_pending) begin
            if (mem_lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
            end else begin
                mem_lat--;
            end
        end
        imem_req_ready = ($urandom_range(99) < p_ready);
        if (stall_hold > 0) begin
            StallF = 1'b1;
            stall_hold--;
        end else begin
            StallF = ($urandom_range(99) < p_stall);
        end
        if (force_redir) begin
            PCSrcE      = 1'b1;
            PCTargetE   = forced_target;
            force_redir = 1'b0;
        end else begin
            PCSrcE = ($urandom_range(99) < p_redir);
            if ($urandom_range(9) == 0)
                PCTargetE = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
            else
                PCTargetE = 32'($urandom_range(1023)) * 32'd4;
        end
    endtask

    // Called mid-cycle: compare outputs, then apply what the coming edge does
    task automatic observe();
        bit consume;
        check("pcplus4", PCPlus4F, PCF + 32'd4);
        check("pcf_model", PCF, model_pc);
        if (!InstrValidF) check("instr_zero", InstrF, 32'h0);
        else              check("instr_data", InstrF, mem_word(PCF));
        if (PCSrcE) check("redir_kills_valid", {31'b0, InstrValidF}, 32'h0);
        if (prev_hold && !PCSrcE) begin
            check("hold_valid", {31'b0, InstrValidF}, 32'h1);
            check("hold_instr", InstrF, prev_instr);
            check("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
        end
        if (prev_req_blocked) begin
            check("req_held", {31'b0, imem_req_valid}, 32'h1);
            check("req_addr_stable", imem_req_addr, prev_addr);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 32'(n_consumed));
        check("perf_squash", perf_squash_cnt, 32'(model_squash));
        if (prev_hold && PCSrcE) model_squash++;
        if (imem_rsp_valid && !InstrValidF) model_squash++;
`endif
        if (imem_rsp_valid) mem_pending = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            check("one_outstanding", {31'b0, mem_pending}, 32'h0);
            mem_pending = 1'b1;
            mem_addr    = imem_req_addr;
            mem_lat     = $urandom_range(lat_max);
            acc_q.push_back(imem_req_addr);
        end
        consume = InstrValidF && !StallF && !PCSrcE;
        if (consume) begin
            con_q.push_back(PCF);
            con_cyc_q.push_back(cyc);
            n_consumed++;
        end
        if (PCSrcE)       model_pc = PCTargetE;
        else if (consume) model_pc = model_pc + 32'd4;
        prev_hold        = InstrValidF && StallF && !PCSrcE;
        prev_instr       = InstrF;
        prev_req_blocked = imem_req_valid && !imem_req_ready;
        prev_addr        = imem_req_addr;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        check({tag, "_req_addr"}, imem_req_addr, c_RESET_PC);
        check({tag, "_valid"}, {31'b0, InstrValidF}, 32'h0);
        check({tag, "_instr"}, InstrF, 32'h0);
        check({tag, "_pcf"}, PCF, c_RESET_PC);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        PCSrcE         = 1'b0;
        StallF         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_pending    = 1'b0;
        model_pc       = c_RESET_PC;
        prev_hold      = 1'b0;
        prev_req_blocked = 1'b0;
        cyc            = 0;
        n_consumed     = 0;
        model_squash   = 0;
        stall_hold     = 0;
        acc_q.delete();
        con_q.delete();
        con_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
`ifdef FETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        check("rst_perf_squash", perf_squash_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
    endtask

    task automatic set_knobs(input int s, input int r, input int rd, input int l);
        p_stall = s;
        p_redir = r;
        p_ready = rd;
        lat_max = l;
    endtask

    initial begin
        force_redir   = 1'b0;
        forced_target = '0;

        // Ideal memory, no stalls: one instruction every second cycle
        set_knobs(0, 0, 100, 0);
        do_reset();
        repeat (7) step();
        check("d36_acc_n", 32'(acc_q.size()), 32'd3);
        check("d36_con_n", 32'(con_q.size()), 32'd3);
        for (int i = 0; i < acc_q.size() && i < 3; i++)
            check("d36_req_addr", acc_q[i], 32'(i * 4));
        for (int i = 0; i < con_q.size() && i < 3; i++) begin
            check("d36_pcf", con_q[i], 32'(i * 4));
            check("d36_cycle", 32'(con_cyc_q[i]), 32'(2 + 2 * i));
        end

        // Stall while the response arrives: held three cycles, consumed once
        do_reset();
        step();
        stall_hold = 3;
        repeat (7) step();
        check("d37_acc_n", 32'(acc_q.size()), 32'd2);
        check("d37_con_n", 32'(con_q.size()), 32'd2);
        if (con_q.size() >= 1) begin
            check("d37_pcf", con_q[0], 32'h0);
            check("d37_cycle", 32'(con_cyc_q[0]), 32'd5);
        end

        // Redirect in IDLE to the last word: PC+4 wraps to zero
        force_redir   = 1'b1;
        forced_target = 32'hFFFF_FFFC;
        do_reset();
        repeat (5) step();
        check("d40_acc_n", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2) begin
            check("d40_first_addr", acc_q[0], 32'hFFFF_FFFC);
            check("d40_wrap_addr", acc_q[1], 32'h0);
        end
        if (con_q.size() >= 1) check("d40_consumed_pc", con_q[0], 32'hFFFF_FFFC);

        // Asynchronous reset while waiting for a response
        force_redir   = 1'b1;
        forced_target = 32'h0000_0200;
        do_reset();
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("d41_async");
        do_reset();
        repeat (3) step();
        check("d41_acc_n", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() >= 1) check("d41_first_addr", acc_q[0], c_RESET_PC);

        // Randomized traffic with stalls, redirects, backpressure and latency
        set_knobs(30, 8, 70, 3);
        do_reset();
        repeat (3000) step();
        check("rand_progress", {31'b0, n_consumed > 200}, 32'h1);

        set_knobs(10, 30, 40, 2);
        do_reset();
        repeat (2000) step();
        check("rand2_progress", {31'b0, n_consumed > 50}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
